// File: rtl/ila_pkg.sv
// Shared definitions for the internal logic analyzer: trigger modes and
// capture state encoding.
package ila_pkg;

    typedef enum logic [1:0] {
        MODE_LEVEL        = 2'd0,
        MODE_EDGE         = 2'd1,
        MODE_PATTERN      = 2'd2,
        MODE_PAT_OR_LEVEL = 2'd3
    } trig_mode_e;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        ARMED   = 2'd1,
        HOLDOFF = 2'd2,
        STOPPED = 2'd3
    } state_e;

endpackage

// File: rtl/ila_sample_ram.sv
// Simple dual-port sample buffer: synchronous write, registered read.
// The read register holds its value between reads.
module ila_sample_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ila_scope_core.sv
// Logic analyzer core: circular capture, trigger qualification with holdoff,
// and oldest-first readout of the frozen buffer.
module ila_scope_core
    import ila_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned HOLDOFF_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    i_data,
    input  logic                     i_trigger,
    input  logic [1:0]               i_mode,
    input  logic [DATA_WIDTH-1:0]    i_trig_mask,
    input  logic [DATA_WIDTH-1:0]    i_trig_value,
    input  logic [HOLDOFF_WIDTH-1:0] i_holdoff,
    input  logic                     i_rearm,
    input  logic                     i_rd_en,
    output logic [DATA_WIDTH-1:0]    o_data,
    output logic                     o_rd_valid,
    output logic                     o_rd_last,
    output logic                     o_primed,
    output logic                     o_triggered,
    output logic                     o_stopped
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
    logic [ADDR_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic                  rd_done_q, rd_done_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  trig_prev_q, trig_prev_d;

    logic                  wr_en;
    logic                  ram_rd_en;
    logic                  pattern_hit;
    logic                  trig_hit;
    logic [ADDR_WIDTH-1:0] hold_clamped;

    // Holdoff saturates at DEPTH-1 so the trigger sample always stays in the buffer.
    if (HOLDOFF_WIDTH > ADDR_WIDTH) begin : g_clamp
        assign hold_clamped = (|i_holdoff[HOLDOFF_WIDTH-1:ADDR_WIDTH]) ? '1
                                                                     : i_holdoff[ADDR_WIDTH-1:0];
    end else begin : g_pass
        assign hold_clamped = ADDR_WIDTH'(i_holdoff);
    end

    assign pattern_hit = ((i_data ^ i_trig_value) & i_trig_mask) == '0;
    assign wr_en       = (state_q != STOPPED);
    assign trig_prev_d = i_trigger;

    always_comb begin
        trig_hit = 1'b0;
        case (trig_mode_e'(i_mode))
            MODE_LEVEL:        trig_hit = i_trigger;
            MODE_EDGE:         trig_hit = i_trigger & ~trig_prev_q;
            MODE_PATTERN:      trig_hit = pattern_hit;
            MODE_PAT_OR_LEVEL: trig_hit = pattern_hit | i_trigger;
            default:           trig_hit = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        fill_cnt_d = fill_cnt_q;
        hold_cnt_d = hold_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        rd_cnt_d   = rd_cnt_q;
        rd_done_d  = rd_done_q;
        valid_d    = 1'b0;
        last_d     = 1'b0;
        ram_rd_en  = 1'b0;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end

        case (state_q)
            FILL: begin
                fill_cnt_d = fill_cnt_q + ADDR_WIDTH'(1);
                if (fill_cnt_q == '1) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (trig_hit) begin
                    if (hold_clamped == '0) begin
                        state_d  = STOPPED;
                        rd_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
                    end else begin
                        state_d    = HOLDOFF;
                        hold_cnt_d = hold_clamped;
                    end
                end
            end
            HOLDOFF: begin
                hold_cnt_d = hold_cnt_q - ADDR_WIDTH'(1);
                if (hold_cnt_q == ADDR_WIDTH'(1)) begin
                    state_d  = STOPPED;
                    rd_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
                end
            end
            STOPPED: begin
                // Rearm takes priority over a coincident read request.
                if (i_rearm) begin
                    state_d    = FILL;
                    fill_cnt_d = '0;
                    rd_cnt_d   = '0;
                    rd_done_d  = 1'b0;
                end else if (i_rd_en && !rd_done_q) begin
                    ram_rd_en = 1'b1;
                    valid_d   = 1'b1;
                    last_d    = (rd_cnt_q == '1);
                    rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(1);
                    rd_cnt_d  = rd_cnt_q + ADDR_WIDTH'(1);
                    rd_done_d = (rd_cnt_q == '1);
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FILL;
            wr_ptr_q    <= '0;
            fill_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            rd_ptr_q    <= '0;
            rd_cnt_q    <= '0;
            rd_done_q   <= 1'b0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            trig_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_cnt_q  <= fill_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_done_q   <= rd_done_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            trig_prev_q <= trig_prev_d;
        end
    end

    ila_sample_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (wr_en),
        .wr_addr(wr_ptr_q),
        .wr_data(i_data),
        .rd_en  (ram_rd_en),
        .rd_addr(rd_ptr_q),
        .rd_data(o_data)
    );

    assign o_rd_valid  = valid_q;
    assign o_rd_last   = last_q;
    assign o_primed    = (state_q != FILL);
    assign o_triggered = (state_q == HOLDOFF) || (state_q == STOPPED);
    assign o_stopped   = (state_q == STOPPED);

endmodule

// File: tb/tb_ila_scope_core.sv
// Scoreboard bench for ila_scope_core: a capture-history model predicts
// status flags and readout; a negedge monitor checks every readout beat.
module tb_ila_scope_core;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int HW = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] i_data = '0;
    logic          i_trigger = 1'b0;
    logic [1:0]    i_mode = 2'd0;
    logic [DW-1:0] i_trig_mask = '0;
    logic [DW-1:0] i_trig_value = '0;
    logic [HW-1:0] i_holdoff = '0;
    logic          i_rearm = 1'b0;
    logic          i_rd_en = 1'b0;
    logic [DW-1:0] o_data;
    logic          o_rd_valid, o_rd_last, o_primed, o_triggered, o_stopped;

    ila_scope_core #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .HOLDOFF_WIDTH(HW)) dut (
        .clk(clk), .reset(reset), .i_data(i_data), .i_trigger(i_trigger),
        .i_mode(i_mode), .i_trig_mask(i_trig_mask), .i_trig_value(i_trig_value),
        .i_holdoff(i_holdoff), .i_rearm(i_rearm), .i_rd_en(i_rd_en),
        .o_data(o_data), .o_rd_valid(o_rd_valid), .o_rd_last(o_rd_last),
        .o_primed(o_primed), .o_triggered(o_triggered), .o_stopped(o_stopped)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: the last DEPTH samples written, plus capture progress flags.
    logic [DW-1:0] hist[$];
    logic [DW:0]   exp_q[$];
    bit            m_primed, m_trig, m_stop, m_prev, m_valid;
    int            m_fill, m_left, m_reads;
    logic [DW-1:0] got[DEPTH];
    int            got_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit pat, hit;
        int h;
        m_valid = 0;
        if (reset) begin
            hist.delete();
            m_primed = 0; m_trig = 0; m_stop = 0; m_prev = 0;
            m_fill = 0; m_left = 0; m_reads = 0;
            return;
        end
        if (m_stop) begin
            if (i_rearm) begin
                m_primed = 0; m_trig = 0; m_stop = 0;
                m_fill = 0; m_reads = 0;
            end else if (i_rd_en && m_reads < DEPTH) begin
                exp_q.push_back({(m_reads == DEPTH - 1), hist[m_reads]});
                m_reads++;
                m_valid = 1;
            end
        end else begin
            hist.push_back(i_data);
            if (hist.size() > DEPTH) void'(hist.pop_front());
            if (!m_primed) begin
                m_fill++;
                if (m_fill == DEPTH) m_primed = 1;
            end else if (!m_trig) begin
                pat = ((i_data ^ i_trig_value) & i_trig_mask) == 0;
                case (i_mode)
                    2'd0: hit = i_trigger;
                    2'd1: hit = i_trigger && !m_prev;
                    2'd2: hit = pat;
                    default: hit = pat || i_trigger;
                endcase
                if (hit) begin
                    h = (int'(i_holdoff) > DEPTH - 1) ? DEPTH - 1 : int'(i_holdoff);
                    m_trig = 1;
                    if (h == 0) m_stop = 1;
                    else m_left = h;
                end
            end else begin
                m_left--;
                if (m_left == 0) m_stop = 1;
            end
        end
        m_prev = i_trigger;
    endtask

    task automatic tick();
        bit was_reset;
        was_reset = reset;
        model_step();
        @(posedge clk);
        #1;
        if (was_reset) i_data = '0;
        else i_data = i_data + 1'b1;
        chk("primed", o_primed, m_primed);
        chk("triggered", o_triggered, m_trig);
        chk("stopped", o_stopped, m_stop);
        chk("rd_valid", o_rd_valid, m_valid);
    endtask

    always @(negedge clk) begin
        if (o_rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got data 0x%0h expected no beat", o_data);
            end else begin
                logic [DW:0] e;
                e = exp_q.pop_front();
                chk("rd_data", o_data, e[DW-1:0]);
                chk("rd_last", o_rd_last, e[DW]);
                if (got_n < DEPTH) got[got_n] = o_data;
                got_n++;
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1; i_rearm = 1'b0; i_rd_en = 1'b0;
        tick(); tick();
        chk("reset_o_data", o_data, 0);
        chk("reset_rd_last", o_rd_last, 0);
        reset = 1'b0;
    endtask

    // Wait for the capture to freeze, raising i_trigger only on the given sample.
    task automatic run_to_stop(input bit use_ext, input logic [DW-1:0] trig_sample);
        int n = 0;
        while (!m_stop && n < 600) begin
            if (use_ext) i_trigger = (i_data == trig_sample);
            tick();
            n++;
        end
        i_trigger = 1'b0;
        chk("capture_stopped", o_stopped, 1);
    endtask

    task automatic readout();
        int extra = 0;
        int n = 0;
        got_n = 0;
        while ((m_reads < DEPTH || extra < 3) && n < 300) begin
            i_rd_en = ($urandom_range(0, 3) != 0);
            if (m_reads == DEPTH && i_rd_en) extra++;
            tick();
            n++;
        end
        i_rd_en = 1'b0;
        tick(); tick();
        chk("read_beats", got_n, DEPTH);
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic rearm();
        i_rearm = 1'b1;
        tick();
        i_rearm = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Fill length and trigger ignored during fill; mode 0 capture with H=4.
        i_mode = 2'd0; i_holdoff = 4;
        do_reset();
        n = 0;
        while (!o_primed && n < 40) begin
            i_trigger = (i_data == 8'd5);
            tick();
            n++;
        end
        i_trigger = 1'b0;
        chk("fill_length", n, 16);
        chk("fill_no_trigger", o_triggered, 0);
        run_to_stop(1, 8'h30);
        readout();
        chk("h4_first", got[0], 8'h25);
        chk("h4_trig_idx11", got[11], 8'h30);
        chk("h4_newest", got[15], 8'h34);

        // Holdoff zero and saturated holdoff.
        i_holdoff = 0;
        do_reset();
        run_to_stop(1, 8'h30);
        readout();
        chk("h0_trig_last", got[15], 8'h30);
        i_holdoff = 20;
        do_reset();
        run_to_stop(1, 8'h30);
        readout();
        chk("hclamp_trig_first", got[0], 8'h30);
        chk("hclamp_newest", got[15], 8'h3F);

        // Pattern trigger, then an all-zero mask.
        i_mode = 2'd2; i_holdoff = 4; i_trig_mask = 8'hF0; i_trig_value = 8'hA0;
        do_reset();
        run_to_stop(0, 8'h00);
        readout();
        chk("pattern_trig", got[11], 8'hA0);
        i_trig_mask = 8'h00;
        do_reset();
        run_to_stop(0, 8'h00);
        readout();
        chk("mask0_trig", got[11], 8'h10);

        // Edge mode with trigger held high from reset.
        i_mode = 2'd1; i_trigger = 1'b1;
        do_reset();
        n = 0;
        while (!m_stop && n < 300) begin
            i_trigger = !(i_data == 8'h3E || i_data == 8'h3F);
            tick();
            n++;
        end
        i_trigger = 1'b0;
        chk("edge_stopped", o_stopped, 1);
        readout();
        chk("edge_trig", got[11], 8'h40);

        // Reset in the middle of holdoff.
        i_mode = 2'd0; i_holdoff = 8;
        do_reset();
        n = 0;
        while (!o_triggered && n < 200) begin
            i_trigger = (i_data == 8'h30);
            tick();
            n++;
        end
        i_trigger = 1'b0;
        chk("holdoff_entered", o_triggered, 1);
        tick(); tick(); tick();
        do_reset();
        chk("midreset_primed", o_primed, 0);
        chk("midreset_triggered", o_triggered, 0);
        chk("midreset_stopped", o_stopped, 0);

        // Full capture, rearm, second capture with rearm racing a read.
        i_holdoff = 4;
        run_to_stop(1, 8'h30);
        readout();
        i_rd_en = 1'b1;
        rearm();
        i_rd_en = 1'b0;
        n = 0;
        while (!o_primed && n < 40) begin tick(); n++; end
        chk("rearm_fill_length", n, 16);
        i_holdoff = 2;
        run_to_stop(1, 8'h60);
        readout();
        chk("rearm_trig", got[13], 8'h60);
        rearm();
        run_to_stop(1, 8'h90);
        got_n = 0;
        for (int k = 0; k < 5; k++) begin i_rd_en = 1'b1; tick(); end
        i_rd_en = 1'b1;
        rearm();
        i_rd_en = 1'b0;
        tick(); tick();
        chk("rearm_beats_partial", got_n, 5);

        // Randomized pattern captures with random holdoff and read gaps.
        for (int r = 0; r < 4; r++) begin
            i_mode = 2'($urandom_range(2, 3));
            i_trig_mask = DW'(1) << $urandom_range(0, DW - 1);
            i_trig_value = DW'($urandom);
            i_holdoff = HW'($urandom_range(0, 24));
            n = 0;
            while (!o_primed && n < 40) begin tick(); n++; end
            run_to_stop(0, 8'h00);
            readout();
            rearm();
        end

        chk("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ila_scope_core.md
Name: ila_scope_core

Overview:
- Parametrised next-generation internal logic analyzer core.
- Continuously records `i_data` into a circular sample buffer.
- Arms once the buffer is full, detects a trigger (external level/edge or masked data pattern), records a programmable holdoff of further samples, then freezes.
- Frozen buffer is streamed out oldest-first over a simple read handshake; the core can be re-armed without reset. Sits beside the user logic under observation; readout feeds the host/debug bridge.

Parameters:
- DATA_WIDTH, 32, width of each captured sample.
- ADDR_WIDTH, 10, buffer address width; DEPTH = 2**ADDR_WIDTH samples.
- HOLDOFF_WIDTH, 16, width of `i_holdoff`.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_data  in  DATA_WIDTH  signals under observation.
- i_trigger  in  1  external trigger.
- i_mode  in  2  trigger mode: 0 ext level, 1 ext rising edge, 2 pattern, 3 pattern OR ext level.
- i_trig_mask  in  DATA_WIDTH  pattern compare mask.
- i_trig_value  in  DATA_WIDTH  pattern compare value.
- i_holdoff  in  HOLDOFF_WIDTH  samples recorded after the trigger sample.
- i_rearm  in  1  restart capture from STOPPED.
- i_rd_en  in  1  request next sample during readout.
- o_data  out  DATA_WIDTH  readout sample.
- o_rd_valid  out  1  `o_data` valid this cycle.
- o_rd_last  out  1  with `o_rd_valid`: newest sample (DEPTH-th read).
- o_primed  out  1  buffer full and trigger armed.
- o_triggered  out  1  trigger accepted (HOLDOFF or STOPPED).
- o_stopped  out  1  capture frozen, readout allowed.

Behaviour:
- Reset values:
  - All outputs 0.
  - `o_data` is 0.
  - Write pointer 0, fill count 0.
  - State FILL.
  - Edge-detect register 0.
- State machine:
  - FILL: write every cycle. After DEPTH writes, go to ARMED and set `o_primed`. Triggers are ignored.
  - ARMED: write every cycle. On the qualifying trigger, that cycle's sample is the trigger sample; load H and go to HOLDOFF.
    - If H == 0, go directly to STOPPED; the trigger sample is the last written.
  - HOLDOFF: write every cycle and decrement. After exactly H further samples are written, go to STOPPED.
  - STOPPED: no writes. Read pointer initialised to the write pointer, i.e. the oldest sample.
- Holdoff: H = min(`i_holdoff`, DEPTH-1), sampled when the trigger is accepted. Later changes to `i_holdoff` are ignored. The trigger sample always lands at index DEPTH-1-H counting from oldest (index 0).
- Trigger qualification:
  - Pattern hit = ((`i_data` ^ `i_trig_value`) & `i_trig_mask`) == 0. A mask of 0 matches every sample.
  - Mode 1 needs `i_trigger` 1 now and 0 in the previous cycle. The edge register updates every cycle, including during FILL.
- Readout:
  - Only in STOPPED. `i_rd_en` in cycle t gives `o_rd_valid` = 1 in cycle t+1 with the addressed sample; 1-cycle RAM latency.
  - Back-to-back reads are allowed. Pointer increments modulo DEPTH.
  - The DEPTH-th read asserts `o_rd_last`. Subsequent `i_rd_en` is ignored; `o_rd_valid` stays 0 until rearm.
  - `o_data` holds its last value when not valid.
- Rearm:
  - `i_rearm` in STOPPED → FILL next cycle, with fill count 0 and `o_primed`/`o_triggered`/`o_stopped` cleared. The write pointer continues.
  - `i_rearm` in any other state is ignored.
  - `i_rearm` together with `i_rd_en`: rearm wins and no valid is produced.
- Reset mid-operation (any state, including HOLDOFF or readout): immediate return to reset values next cycle.
- `i_mode` is sampled live. Changing it is only defined in FILL or STOPPED.

Decomposition:
- Shared package ila_pkg: trigger mode constants (MODE_LEVEL, MODE_EDGE, MODE_PATTERN, MODE_PAT_OR_LEVEL) and state encoding (FILL, ARMED, HOLDOFF, STOPPED).
- Sub-module ila_sample_ram: simple dual-port RAM, DATA_WIDTH x DEPTH, one synchronous write port, one registered read port. Inferable as block RAM.
- FSM, counters and trigger logic stay in ila_scope_core.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=4, DEPTH=16, `i_data` = free-running count from 0 after reset release):
1. Fill: release reset, no trigger → `o_primed` rises after exactly 16 writes. `i_trigger` pulsed at write 5 does not set `o_triggered`.
2. Mode 0, H=4, `i_trigger` high on the sample 0x30 → `o_stopped` after 0x34 is written. 16 reads return 0x25..0x34 in order, 0x30 at index 11, `o_rd_last` only with 0x34, 17th read gives no valid.
3. H=0 → trigger sample 0x30 is the last read. `i_holdoff`=20 → clamped to 15, trigger sample is the first read (0x30..0x3F).
4. Mode 2, mask 0xF0, value 0xA0, primed at 0x10 → trigger on sample 0xA0, never earlier. Mask 0x00 → trigger on the first armed sample, 0x10.
5. Mode 1, `i_trigger` held high from reset → no trigger while high. Drop to 0, raise at sample 0x40 → trigger sample 0x40.
6. Reset asserted during HOLDOFF, then a separate run with `i_rearm` after a full readout → all outputs 0 after reset. After rearm, `o_primed` returns after 16 new writes and a second capture reads back correctly.
